// File: rtl/adc_demux_pkg.sv
// Shared defaults and channel-index width derivation for the ADC channel demultiplexer.
package adc_demux_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int NUM_CH_DEF = 8;

    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/adc_chan_slot.sv
// One output channel: sample register, valid/overrun flags and optional pair averaging.
// Averaging is enabled by defining ADC_DEMUX_AVG_EN.
module adc_chan_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ack,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_overrun,
    output logic              o_commit
);
    logic              w_commit;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;

`ifdef ADC_DEMUX_AVG_EN
    logic              r_pend_full;
    logic [DATA_W-1:0] r_pend_data;
    logic [DATA_W:0]   w_sum;

    // The first sample of a pair only parks in the pending register.
    assign w_sum    = {1'b0, r_pend_data} + {1'b0, i_data};
    assign w_commit = i_wr & r_pend_full;
    assign w_wdata  = w_sum[DATA_W:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_full <= 1'b0;
            r_pend_data <= '0;
        end else if (i_wr) begin
            r_pend_full <= ~r_pend_full;
            if (!r_pend_full)
                r_pend_data <= i_data;
        end
    end
`else
    assign w_commit = i_wr;
    assign w_wdata  = i_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_commit) begin
            r_data  <= w_wdata;
            r_valid <= 1'b1;
            // A simultaneous ack means the old sample was consumed, so no overrun.
            if (r_valid && !i_ack)
                r_overrun <= 1'b1;
        end else if (i_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
    assign o_commit  = w_commit;
endmodule

// File: rtl/adc_chan_demux.sv
// ADC sample demultiplexer: routes samples to per-channel holding registers by scan or manual select.
// Optional per-channel pair averaging is enabled by defining ADC_DEMUX_AVG_EN.
module adc_chan_demux
    import adc_demux_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NUM_CH = NUM_CH_DEF,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_W-1:0]        adc_data,
    input  logic                     adc_valid,
    input  logic                     auto_scan,
    input  logic [CH_W-1:0]          ch_sel,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ack,
    output logic [NUM_CH-1:0]        overrun,
    output logic [CH_W-1:0]          cur_ch
);
    logic [CH_W-1:0]   r_cur_ch;
    logic [CH_W-1:0]   w_target;
    logic              w_accept;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_commit;

    assign w_target = auto_scan ? r_cur_ch : ch_sel;
    // Out-of-range manual selections are dropped before they reach any slot.
    assign w_accept = en && adc_valid && (int'(w_target) < NUM_CH);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign w_wr[gi] = w_accept && (w_target == CH_W'(gi));

            adc_chan_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .i_wr      (w_wr[gi]),
                .i_data    (adc_data),
                .i_ack     (out_ack[gi]),
                .o_data    (out_data[gi*DATA_W +: DATA_W]),
                .o_valid   (out_valid[gi]),
                .o_overrun (overrun[gi]),
                .o_commit  (w_commit[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_ch <= '0;
        end else if (auto_scan && (|w_commit)) begin
            if (r_cur_ch == CH_W'(NUM_CH - 1))
                r_cur_ch <= '0;
            else
                r_cur_ch <= r_cur_ch + 1'b1;
        end
    end

    assign cur_ch = r_cur_ch;
endmodule

// File: tb/tb_adc_chan_demux.sv
// Directed self-checking bench for adc_chan_demux (DATA_W=8, NUM_CH=4).
module tb_adc_chan_demux;
    localparam int DW = 8;
    localparam int NC = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          auto_scan;
    logic [CW-1:0] ch_sel;
    logic [NC*DW-1:0] out_data;
    logic [NC-1:0] out_valid;
    logic [NC-1:0] out_ack;
    logic [NC-1:0] overrun;
    logic [CW-1:0] cur_ch;

    int n_pass  = 0;
    int n_total = 0;

    adc_chan_demux #(.DATA_W(DW), .NUM_CH(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .auto_scan (auto_scan),
        .ch_sel    (ch_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .overrun   (overrun),
        .cur_ch    (cur_ch)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; adc_valid = 1'b0; out_ack = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle();
        step();
        rst = 1'b0;
    endtask

    task automatic sample(input logic [DW-1:0] d);
        adc_data = d; adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b0; adc_data = '0; adc_valid = 1'b0; auto_scan = 1'b1; ch_sel = '0; out_ack = '0;
        do_reset();
        n_total++; if (out_data !== 32'h0) $display("FAIL reset_data got=%h exp=%h", out_data, 32'h0); else n_pass++;
        n_total++; if (out_valid !== 4'b0) $display("FAIL reset_valid got=%b exp=%b", out_valid, 4'b0); else n_pass++;
        n_total++; if (overrun !== 4'b0) $display("FAIL reset_overrun got=%b exp=%b", overrun, 4'b0); else n_pass++;
        n_total++; if (cur_ch !== 2'd0) $display("FAIL reset_cur_ch got=%0d exp=0", cur_ch); else n_pass++;
        $display("txn reset done");
    endtask

    task automatic test_auto_scan();
        auto_scan = 1'b1;
        sample(8'h11);
        n_total++; if (out_valid !== 4'b0001) $display("FAIL scan_latency got=%b exp=%b", out_valid, 4'b0001); else n_pass++;
        sample(8'h22); sample(8'h33); sample(8'h44);
        n_total++; if (out_data !== 32'h44332211) $display("FAIL scan_data got=%h exp=%h", out_data, 32'h44332211); else n_pass++;
        n_total++; if (out_valid !== 4'b1111) $display("FAIL scan_valid got=%b exp=%b", out_valid, 4'b1111); else n_pass++;
        n_total++; if (cur_ch !== 2'd0) $display("FAIL scan_wrap got=%0d exp=0", cur_ch); else n_pass++;
        n_total++; if (overrun !== 4'b0000) $display("FAIL scan_no_ovr got=%b exp=%b", overrun, 4'b0000); else n_pass++;
        sample(8'h55);
        n_total++; if (out_data !== 32'h44332255) $display("FAIL scan_overwrite got=%h exp=%h", out_data, 32'h44332255); else n_pass++;
        n_total++; if (overrun !== 4'b0001) $display("FAIL scan_overrun got=%b exp=%b", overrun, 4'b0001); else n_pass++;
        n_total++; if (cur_ch !== 2'd1) $display("FAIL scan_cur_ch got=%0d exp=1", cur_ch); else n_pass++;
        $display("txn auto_scan done data=%h ovr=%b cur=%0d", out_data, overrun, cur_ch);
    endtask

    task automatic test_manual();
        do_reset();
        auto_scan = 1'b1;
        sample(8'h10);
        out_ack = 4'b0001;
        step();
        out_ack = '0;
        n_total++; if (out_valid !== 4'b0000) $display("FAIL ack_clear got=%b exp=%b", out_valid, 4'b0000); else n_pass++;
        n_total++; if (out_data[7:0] !== 8'h10) $display("FAIL ack_hold_data got=%h exp=%h", out_data[7:0], 8'h10); else n_pass++;
        auto_scan = 1'b0; ch_sel = 2'd2;
        sample(8'hA5);
        n_total++; if (out_data[23:16] !== 8'hA5) $display("FAIL manual_data got=%h exp=%h", out_data[23:16], 8'hA5); else n_pass++;
        n_total++; if (out_valid !== 4'b0100) $display("FAIL manual_valid got=%b exp=%b", out_valid, 4'b0100); else n_pass++;
        n_total++; if (cur_ch !== 2'd1) $display("FAIL manual_cur_ch got=%0d exp=1", cur_ch); else n_pass++;
        $display("txn manual ch2 data=%h valid=%b", out_data, out_valid);
    endtask

    task automatic test_ack_write();
        ch_sel = 2'd2; out_ack = 4'b0100;
        sample(8'h5A);
        out_ack = '0;
        n_total++; if (out_valid !== 4'b0100) $display("FAIL ackwr_valid got=%b exp=%b", out_valid, 4'b0100); else n_pass++;
        n_total++; if (out_data[23:16] !== 8'h5A) $display("FAIL ackwr_data got=%h exp=%h", out_data[23:16], 8'h5A); else n_pass++;
        n_total++; if (overrun !== 4'b0000) $display("FAIL ackwr_overrun got=%b exp=%b", overrun, 4'b0000); else n_pass++;
        out_ack = 4'b1000;
        step();
        out_ack = '0;
        n_total++; if (out_valid !== 4'b0100) $display("FAIL ack_idle_ch got=%b exp=%b", out_valid, 4'b0100); else n_pass++;
        $display("txn ack+write ch2 valid=%b ovr=%b", out_valid, overrun);
    endtask

    task automatic test_en_low();
        auto_scan = 1'b1; en = 1'b0; adc_valid = 1'b1; adc_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (out_data !== 32'h005A0010) $display("FAIL en_low_data[%0d] got=%h exp=%h", i, out_data, 32'h005A0010); else n_pass++;
            n_total++; if (out_valid !== 4'b0100) $display("FAIL en_low_valid[%0d] got=%b exp=%b", i, out_valid, 4'b0100); else n_pass++;
            n_total++; if (cur_ch !== 2'd1) $display("FAIL en_low_cur[%0d] got=%0d exp=1", i, cur_ch); else n_pass++;
        end
        adc_valid = 1'b0; en = 1'b1;
        $display("txn en_low 3 cycles held");
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        auto_scan = 1'b1;
        sample(8'h21); sample(8'h22);
        n_total++; if (cur_ch !== 2'd2) $display("FAIL mid_cur got=%0d exp=2", cur_ch); else n_pass++;
        rst = 1'b1; adc_valid = 1'b1; adc_data = 8'h99;
        step();
        rst = 1'b0; adc_valid = 1'b0;
        n_total++; if (out_data !== 32'h0) $display("FAIL mid_rst_data got=%h exp=%h", out_data, 32'h0); else n_pass++;
        n_total++; if (out_valid !== 4'b0) $display("FAIL mid_rst_valid got=%b exp=%b", out_valid, 4'b0); else n_pass++;
        n_total++; if (cur_ch !== 2'd0) $display("FAIL mid_rst_cur got=%0d exp=0", cur_ch); else n_pass++;
        sample(8'h66);
        n_total++; if (out_data !== 32'h00000066) $display("FAIL post_rst_data got=%h exp=%h", out_data, 32'h00000066); else n_pass++;
        n_total++; if (out_valid !== 4'b0001) $display("FAIL post_rst_valid got=%b exp=%b", out_valid, 4'b0001); else n_pass++;
        n_total++; if (cur_ch !== 2'd1) $display("FAIL post_rst_cur got=%0d exp=1", cur_ch); else n_pass++;
        $display("txn reset mid-scan, next sample ch0=%h", out_data[7:0]);
    endtask

    task automatic test_average();
        do_reset();
        auto_scan = 1'b0; ch_sel = 2'd1;
        sample(8'hFF);
`ifdef ADC_DEMUX_AVG_EN
        n_total++; if (out_valid !== 4'b0000) $display("FAIL avg_first_valid got=%b exp=%b", out_valid, 4'b0000); else n_pass++;
        sample(8'h01);
        n_total++; if (out_data[15:8] !== 8'h80) $display("FAIL avg_data got=%h exp=%h", out_data[15:8], 8'h80); else n_pass++;
        n_total++; if (out_valid !== 4'b0010) $display("FAIL avg_valid got=%b exp=%b", out_valid, 4'b0010); else n_pass++;
        auto_scan = 1'b1;
        sample(8'h10);
        n_total++; if (cur_ch !== 2'd0) $display("FAIL avg_cur_hold got=%0d exp=0", cur_ch); else n_pass++;
        sample(8'h20);
        n_total++; if (cur_ch !== 2'd1) $display("FAIL avg_cur_adv got=%0d exp=1", cur_ch); else n_pass++;
        n_total++; if (out_data[7:0] !== 8'h18) $display("FAIL avg_ch0 got=%h exp=%h", out_data[7:0], 8'h18); else n_pass++;
`else
        n_total++; if (out_data[15:8] !== 8'hFF) $display("FAIL pass_first got=%h exp=%h", out_data[15:8], 8'hFF); else n_pass++;
        n_total++; if (out_valid !== 4'b0010) $display("FAIL pass_valid got=%b exp=%b", out_valid, 4'b0010); else n_pass++;
        sample(8'h01);
        n_total++; if (out_data[15:8] !== 8'h01) $display("FAIL pass_second got=%h exp=%h", out_data[15:8], 8'h01); else n_pass++;
        n_total++; if (overrun !== 4'b0010) $display("FAIL pass_overrun got=%b exp=%b", overrun, 4'b0010); else n_pass++;
`endif
        $display("txn pair to ch1 data=%h valid=%b", out_data[15:8], out_valid);
    endtask

    initial begin
        test_reset();
        test_auto_scan();
        test_manual();
        test_ack_write();
        test_en_low();
        test_reset_mid_scan();
        test_average();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/adc_chan_demux.md
ADC_CHAN_DEMUX -- requirements
Module: adc_chan_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 8: ADC sample width in bits, legal range 2..16.
REQ-002 SHALL have parameter NUM_CH, default 8: number of output channels, legal range 2..16 (CH_W = clog2(NUM_CH)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: global capture enable.
REQ-006 SHALL have port adc_data, input, DATA_W bits: ADC sample word.
REQ-007 SHALL have port adc_valid, input, 1 bit: adc_data is valid this cycle.
REQ-008 SHALL have port auto_scan, input, 1 bit: 1 = round-robin channel target, 0 = manual target.
REQ-009 SHALL have port ch_sel, input, CH_W bits: manual target channel.
REQ-010 SHALL have port out_data, output, NUM_CH*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port out_valid, output, NUM_CH bits: per-channel sample-held flag.
REQ-012 SHALL have port out_ack, input, NUM_CH bits: per-channel consumer acknowledge.
REQ-013 SHALL have port overrun, output, NUM_CH bits: sticky per-channel overwrite flag.
REQ-014 SHALL have port cur_ch, output, CH_W bits: current scan pointer.

Function
REQ-015 SHALL accept a sample only in a cycle with en=1 and adc_valid=1; otherwise ignore adc_data, and all outputs hold.
REQ-016 SHALL select the target channel as cur_ch when auto_scan=1, else ch_sel; ch_sel >= NUM_CH discards the sample.
REQ-017 SHALL write an accepted sample to the target channel register and set its out_valid on the next rising edge (latency 1 cycle).
REQ-018 SHALL increment cur_ch after each accepted sample while auto_scan=1, wrapping NUM_CH-1 -> 0; cur_ch holds when auto_scan=0, and toggling auto_scan does not move cur_ch.
REQ-019 SHALL clear out_valid[k] on the edge after a cycle with out_ack[k]=1; an ack to a channel with out_valid=0 has no effect.
REQ-020 SHALL, on a write and an ack to the same channel in one cycle, perform the write: out_valid stays 1, overrun is unchanged.
REQ-021 SHALL, on a write to a channel with out_valid=1 and no ack, overwrite its data and set overrun[k]; overrun stays set until rst.
REQ-022 SHALL hold out_data[k] unchanged after ack until the next write to channel k.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, clear out_data, out_valid, overrun, cur_ch and any averaging state to 0; rst takes priority over every other input, including mid-scan.
REQ-024 SHALL accept samples normally in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with ADC_DEMUX_AVG_EN defined, average sample pairs per channel: the first accepted sample is stored in a per-channel pending register, and only the second produces a write of (a+b)>>1, computed at DATA_W+1 bits and truncated. Only that second sample asserts out_valid and advances cur_ch. Each accepted sample advances cur_ch only in pass-through mode.
REQ-026 SHALL, without ADC_DEMUX_AVG_EN, pass samples through unmodified, with no pending registers synthesised.

Structure
REQ-027 SHALL place DATA_W/NUM_CH defaults and the CH_W derivation in shared package adc_demux_pkg.
REQ-028 SHALL implement per-channel data, valid, overrun and averaging logic in sub-module adc_chan_slot, instantiated NUM_CH times by generate.

Verification
REQ-029 SHALL cover, with DATA_W=8, NUM_CH=4, auto_scan=1: samples 0x11,0x22,0x33,0x44,0x55 -> ch0..3 = 0x11..0x44, then ch0 = 0x55 with overrun[0]=1, cur_ch=1.
REQ-030 SHALL cover: manual ch_sel=2, sample 0xA5 -> out_data[2]=0xA5, out_valid=4'b0100 one cycle later, cur_ch unchanged.
REQ-031 SHALL cover: out_ack[2]=1 together with a new sample 0x5A to ch2 -> out_valid[2] stays 1, data=0x5A, overrun[2]=0.
REQ-032 SHALL cover: en=0 with adc_valid=1 for 3 cycles -> no output changes, cur_ch unchanged.
REQ-033 SHALL cover: rst asserted after 2 scanned samples -> all outputs 0 next edge, next sample lands in ch0.
REQ-034 SHALL cover, with ADC_DEMUX_AVG_EN: samples 0xFF,0x01 to ch1 -> out_data[1]=0x80, out_valid[1] set only after the second sample.
